// File: rtl/branch_resolver_pkg.sv
// Shared types for the execute-stage branch resolver: op codes, FSM states,
// address width and the JALR alignment helper.
package branch_resolver_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BEQ     = 4'd1,
        BNE     = 4'd2,
        BLT     = 4'd3,
        BGE     = 4'd4,
        BLTU    = 4'd5,
        BGEU    = 4'd6,
        JAL     = 4'd7,
        JALR    = 4'd8
    } br_op_e;

    typedef enum logic {
        RES_IDLE  = 1'b0,
        RES_FLUSH = 1'b1
    } res_state_e;

    function automatic logic [ADDR_W-1:0] jalr_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// EX-stage branch bundle: instruction fields into the resolver, predictor
// update, redirect/flush controls and statistics counters out of it.
interface branch_resolver_if;
    import branch_resolver_pkg::*;

    logic              ex_valid;
    logic              ex_stall;
    logic [3:0]        ex_op;
    logic [ADDR_W-1:0] ex_pc;
    logic [ADDR_W-1:0] ex_rs1;
    logic [ADDR_W-1:0] ex_rs2;
    logic [ADDR_W-1:0] ex_imm;
    logic              ex_prediction;
    logic [ADDR_W-1:0] ex_pred_target;

    logic              br_update;
    logic              br;
    logic [ADDR_W-1:0] br_address;
    logic [ADDR_W-1:0] br_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic [31:0]       br_count;
    logic [31:0]       miss_count;

    modport slave (
        input  ex_valid, ex_stall, ex_op, ex_pc, ex_rs1, ex_rs2, ex_imm,
               ex_prediction, ex_pred_target,
        output br_update, br, br_address, br_pc, redirect, redirect_pc,
               flush, br_count, miss_count
    );

    modport master (
        output ex_valid, ex_stall, ex_op, ex_pc, ex_rs1, ex_rs2, ex_imm,
               ex_prediction, ex_pred_target,
        input  br_update, br, br_address, br_pc, redirect, redirect_pc,
               flush, br_count, miss_count
    );

endinterface

// File: rtl/branch_resolver_cmp.sv
// Combinational branch condition evaluator: op and operands to taken.
module branch_cmp
    import branch_resolver_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    output logic              taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            BEQ:       taken_o = (rs1_i == rs2_i);
            BNE:       taken_o = (rs1_i != rs2_i);
            BLT:       taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            BGE:       taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            BLTU:      taken_o = (rs1_i <  rs2_i);
            BGEU:      taken_o = (rs1_i >= rs2_i);
            JAL, JALR: taken_o = 1'b1;
            default:   taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: target computation, mispredict detection,
// redirect/flush sequencing, predictor update and statistics counters.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    branch_resolver_if.slave bus
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    res_state_e        state_q, state_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              br_update_q, br_update_d;
    logic              br_q, br_d;
    logic [ADDR_W-1:0] br_address_q, br_address_d;
    logic [ADDR_W-1:0] br_pc_q, br_pc_d;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]       br_count_q, br_count_d;
    logic [31:0]       miss_count_q, miss_count_d;

    logic              taken;
    logic              resolve;
    logic              mispredict;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;

    branch_cmp u_cmp (
        .op_i    (bus.ex_op),
        .rs1_i   (bus.ex_rs1),
        .rs2_i   (bus.ex_rs2),
        .taken_o (taken)
    );

    always_comb begin
        if (bus.ex_op == JALR) begin
            target = jalr_align(bus.ex_rs1 + bus.ex_imm);
        end else begin
            target = bus.ex_pc + bus.ex_imm;
        end
        next_pc = taken ? target : (bus.ex_pc + ADDR_W'(4));
    end

    // Instructions seen while flushing are wrong-path and never resolve.
    assign resolve = bus.ex_valid && !bus.ex_stall && (bus.ex_op != BR_NONE)
                     && (state_q == RES_IDLE);

    assign mispredict = resolve &&
                        ((taken != bus.ex_prediction) ||
                         (taken && bus.ex_prediction && (target != bus.ex_pred_target)));

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == RES_IDLE) begin
            if (mispredict) begin
                state_d     = RES_FLUSH;
                flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
            end
        end else begin
            if (flush_cnt_q == '0) begin
                state_d = RES_IDLE;
            end else begin
                flush_cnt_d = flush_cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        br_update_d   = resolve;
        br_d          = br_q;
        br_address_d  = br_address_q;
        br_pc_d       = br_pc_q;
        redirect_d    = mispredict;
        redirect_pc_d = redirect_pc_q;
        br_count_d    = br_count_q;
        miss_count_d  = miss_count_q;
        if (resolve) begin
            br_d         = taken;
            br_address_d = target;
            br_pc_d      = bus.ex_pc;
            br_count_d   = br_count_q + 32'd1;
        end
        if (mispredict) begin
            redirect_pc_d = next_pc;
            miss_count_d  = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RES_IDLE;
            flush_cnt_q   <= '0;
            br_update_q   <= 1'b0;
            br_q          <= 1'b0;
            br_address_q  <= '0;
            br_pc_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            br_count_q    <= '0;
            miss_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            br_update_q   <= br_update_d;
            br_q          <= br_d;
            br_address_q  <= br_address_d;
            br_pc_q       <= br_pc_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            br_count_q    <= br_count_d;
            miss_count_q  <= miss_count_d;
        end
    end

    assign bus.br_update   = br_update_q;
    assign bus.br          = br_q;
    assign bus.br_address  = br_address_q;
    assign bus.br_pc       = br_pc_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.flush       = (state_q == RES_FLUSH);
    assign bus.br_count    = br_count_q;
    assign bus.miss_count  = miss_count_q;

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution and misprediction recovery. Evaluates each branch/jump leaving ID/EX and compares the actual outcome with the fetch-time prediction carried down the pipe. On a mismatch it redirects `pc_reg` and flushes the wrong-path stages. It is also the writer of the branch predictor's update port (`br_update`, `br`, `br_address`, `br_pc`).

## Interface
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a redirect (≥1).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset (reset when `rst==0`).
- `ex_valid` in 1: ID/EX holds a real instruction.
- `ex_stall` in 1: EX is frozen this cycle; the instruction is not consumed.
- `ex_op` in 4: branch kind, encoded with `BR_*` constants.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_rs1`, `ex_rs2` in 32 each: operand values.
- `ex_imm` in 32: sign-extended immediate.
- `ex_prediction` in 1: predicted taken at fetch.
- `ex_pred_target` in 32: fetch-time next PC (`_pc` captured in IF/ID).
- `br_update` out 1: predictor write strobe.
- `br` out 1: resolved taken.
- `br_address` out 32: resolved target.
- `br_pc` out 32: branch PC.
- `redirect` out 1: one-cycle PC override pulse.
- `redirect_pc` out 32: correct next PC.
- `flush` out 1: kill IF/ID and ID/EX contents.
- `br_count`, `miss_count` out 32 each: resolved-branch and misprediction counters.

## Operation
- Resolve event: `ex_valid && !ex_stall && ex_op!=BR_NONE && state==IDLE`. Nothing happens for `BR_NONE`, a stalled EX, or while in FLUSH; those instructions are wrong-path.
- Taken condition:
  - `BEQ`/`BNE`: equality.
  - `BLT`/`BGE`: signed compare.
  - `BLTU`/`BGEU`: unsigned compare.
  - `JAL`/`JALR`: always taken.
- Target:
  - Conditional branches and `JAL`: `ex_pc+ex_imm`, mod 2^32.
  - `JALR`: `(ex_rs1+ex_imm)&~1`.
- Actual next PC: `taken ? target : ex_pc+4`.
- Mispredict when `taken != ex_prediction`, or when `taken && ex_prediction && target != ex_pred_target`.
- Every resolve event:
  - Registers `br_update=1`, `br=taken`, `br_address=target` (the target even when not taken), `br_pc=ex_pc`.
  - Increments `br_count`.
- On a mispredict, additionally:
  - Pulses `redirect` with `redirect_pc` = actual next PC.
  - Increments `miss_count`.
  - Enters FLUSH.
- FSM:
  - IDLE→FLUSH on mispredict; `flush_cnt` loads `FLUSH_CYCLES-1`.
  - FLUSH decrements `flush_cnt` every cycle, independent of `ex_stall`.
  - FLUSH→IDLE when `flush_cnt==0`.
- Counters wrap at 2^32.

## Timing
- All outputs are registered. The event at edge N is visible after edge N, for exactly one cycle for `br_update` and `redirect`.
- `flush` is high for exactly `FLUSH_CYCLES` cycles, starting the same cycle as `redirect`.
- A correctly predicted branch produces `br_update` only; `redirect` and `flush` stay 0.
- Back-to-back resolve events in IDLE give back-to-back `br_update` pulses with no bubble.
- An event arriving on the last FLUSH cycle is ignored. The first cycle eligible to resolve is the one after `flush` drops.
- Reset values: all outputs 0, `redirect_pc`/`br_address`/`br_pc` = 0, counters 0, state IDLE.
- Reset mid-FLUSH aborts immediately; `flush` is 0 the cycle after the reset edge.

## Structure
- `defines.v` holds the `BR_NONE=0`, `BEQ=1`, `BNE=2`, `BLT=3`, `BGE=4`, `BLTU=5`, `BGEU=6`, `JAL=7`, `JALR=8` codes and the state encodings `RES_IDLE`/`RES_FLUSH`. Width comes from `` `Instruction_Address_size ``.
- Sub-module `branch_cmp` is purely combinational: op, rs1, rs2 → taken.
- Top-level `branch_resolver` holds target arithmetic, mispredict detection, FSM, output registers and counters.

## Test plan
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, prediction=1, pred_target=0x120 → `br_update=1`, `br=1`, `br_address=0x120`, no redirect, `br_count=1`.
- BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x40, prediction=0 → taken; `redirect_pc=0x240`; `flush` high for 2 cycles; `miss_count=1`.
- BLTU with the same operands, prediction=1, pred_target=0x240 → not taken; `redirect_pc=0x204`; `br_address=0x240`; `br=0`.
- JALR, rs1=0x1003, imm=0x4, prediction=1, pred_target=0x1000 → target 0x1006 ≠ 0x1000; redirect to 0x1006.
- Mispredict followed by BEQ events during both flush cycles, plus one with `ex_stall=1` → no `br_update`, `br_count` unchanged; the next event after `flush` falls is resolved.
- `rst=0` on the first FLUSH cycle → next cycle `flush=0`, counters 0, state IDLE; a following branch resolves normally.
